// File: rtl/up_prog_tx.sv
// Host-side loader for the up serial programming port: raises prog, sends the
// 0x55/0xAA autobaud pair, then streams a 256-byte image from address 255 down to 0.
module up_prog_tx #(
    parameter int CLK_DIV  = 5,
    parameter int GAP_CYC  = 25,
    parameter int LEAD_CYC = 50,
    parameter int TAIL_CYC = 5
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       prog,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [8:0] byte_cnt
);

    localparam int M1   = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int M2   = (LEAD_CYC > TAIL_CYC) ? LEAD_CYC : TAIL_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC);

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD_CYC - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD, GAP, START, DATA, STOP, TAIL
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bidx;
    logic [8:0]     k;
    logic [7:0]     sh;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= IDLE;
            cnt      <= '0;
            bidx     <= '0;
            k        <= '0;
            sh       <= '0;
            rd_addr  <= 8'hFF;
            prog     <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // byte_cnt is deliberately left alone so the host can see how far it got
                state   <= IDLE;
                cnt     <= '0;
                bidx    <= '0;
                k       <= '0;
                rd_addr <= 8'hFF;
                prog    <= 1'b0;
                tx      <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        prog <= 1'b0;
                        if (start && !abort) begin
                            state    <= LEAD;
                            prog     <= 1'b1;
                            busy     <= 1'b1;
                            byte_cnt <= '0;
                            cnt      <= '0;
                            k        <= '0;
                        end
                    end
                    LEAD: begin
                        if (cnt == LEAD_LAST) begin
                            cnt     <= '0;
                            state   <= GAP;
                            rd_addr <= 8'd1 - k[7:0];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        tx <= 1'b1;
                        if (cnt == GAP_LAST) begin
                            // rd_addr has been stable since GAP entry, so rd_data is valid here
                            cnt   <= '0;
                            sh    <= (k == 9'd0) ? 8'h55 : (k == 9'd1) ? 8'hAA : rd_data;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == DIV_LAST) begin
                            cnt   <= '0;
                            tx    <= sh[0];
                            sh    <= {1'b0, sh[7:1]};
                            bidx  <= '0;
                            state <= DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == DIV_LAST) begin
                            cnt <= '0;
                            if (bidx == 3'd7) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                tx   <= sh[0];
                                sh   <= {1'b0, sh[7:1]};
                                bidx <= bidx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == DIV_LAST) begin
                            cnt      <= '0;
                            byte_cnt <= byte_cnt + 9'd1;
                            if (k != 9'd257) begin
                                k       <= k + 9'd1;
                                rd_addr <= 8'd0 - k[7:0];
                                state   <= GAP;
                            end else begin
                                state <= TAIL;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    TAIL: begin
                        if (cnt == TAIL_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            prog  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        prog  <= 1'b0;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_up_prog_tx.sv
// Randomized scoreboard bench for up_prog_tx: a UART sniffer decodes tx frames
// and checks each one, bit by bit and cycle by cycle, against the expected byte stream.
module tb_up_prog_tx;

    localparam int CLK_DIV  = 5;
    localparam int GAP_CYC  = 25;
    localparam int LEAD_CYC = 50;
    localparam int TAIL_CYC = 5;
    localparam int FRAME    = GAP_CYC + 10 * CLK_DIV;
    localparam int LOAD_LAT = LEAD_CYC + 258 * FRAME + TAIL_CYC;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       prog, tx, busy, done;
    logic [8:0] byte_cnt;

    logic [7:0] mem    [256];
    logic [7:0] rx_mem [256];
    logic [7:0] exp_q  [$];

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // synchronous image ROM, one cycle of read latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    up_prog_tx #(
        .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .LEAD_CYC(LEAD_CYC), .TAIL_CYC(TAIL_CYC)
    ) dut (
        .clk(clk), .nRst(nRst), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .prog(prog), .tx(tx),
        .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model of one load: sync pair then the image from the top address down
    task automatic push_image();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        for (int a = 255; a >= 0; a--) exp_q.push_back(mem[a]);
    endtask

    // returns at the falling edge inside the first busy cycle
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // UART sniffer / scoreboard monitor
    logic       sn_act = 1'b0;
    logic       sn_have;
    logic       sn_bad;
    logic [7:0] sn_exp;
    logic [7:0] sn_byte;
    int         sn_t;
    int         sn_k = 0;

    always @(negedge clk) begin
        if (nRst !== 1'b1 || prog !== 1'b1) begin
            sn_act = 1'b0;
            sn_k   = 0;
        end else begin
            if (!sn_act && tx === 1'b0) begin
                sn_act  = 1'b1;
                sn_t    = 0;
                sn_bad  = 1'b0;
                sn_byte = 8'h00;
                sn_have = (exp_q.size() > 0);
                sn_exp  = sn_have ? exp_q[0] : 8'h00;
            end
            if (sn_act) begin
                int   slot;
                logic eb;
                slot = sn_t / CLK_DIV;
                eb   = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : sn_exp[slot-1];
                if (tx !== eb) sn_bad = 1'b1;
                if (slot >= 1 && slot <= 8 && (sn_t % CLK_DIV) == CLK_DIV / 2)
                    sn_byte[slot-1] = tx;
                if (sn_t == 10 * CLK_DIV - 1) begin
                    if (!sn_have) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame", sn_byte);
                    end else begin
                        check($sformatf("frame%0d_byte", sn_k), {24'd0, sn_byte}, {24'd0, sn_exp});
                        check($sformatf("frame%0d_shape", sn_k), {31'd0, sn_bad}, 32'd0);
                        void'(exp_q.pop_front());
                    end
                    if (sn_k >= 2 && sn_k <= 257) rx_mem[257 - sn_k] = sn_byte;
                    sn_k++;
                    sn_act = 1'b0;
                end else begin
                    sn_t++;
                end
            end
        end
    end

    initial begin
        int n, first_low, off, bad;

        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;

        // reset and idle
        nRst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_prog", {31'd0, prog}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_byte_cnt", {23'd0, byte_cnt}, 32'd0);
        check("rst_rd_addr", {24'd0, rd_addr}, 32'hFF);
        nRst = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || prog !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 8'hFF)
                bad++;
        end
        check("idle_stable", bad, 0);

        // start and abort together in IDLE: abort wins
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", {31'd0, busy}, 32'd0);
        check("start_abort_idle_prog", {31'd0, prog}, 32'd0);

        // full image load, with an ignored second start during frame 10
        push_image();
        pulse_start();
        check("load1_busy_rise", {31'd0, busy}, 32'd1);
        check("load1_prog_rise", {31'd0, prog}, 32'd1);
        n = 0;
        first_low = -1;
        while (done !== 1'b1 && n < LOAD_LAT + 1000) begin
            if (first_low < 0 && tx === 1'b0) first_low = n;
            start = (n == LEAD_CYC + 10 * FRAME + 12);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("load1_lead_gap_high", first_low, LEAD_CYC + GAP_CYC);
        check("load1_latency", n, LOAD_LAT);
        check("load1_byte_cnt", {23'd0, byte_cnt}, 32'd258);
        check("load1_done_busy", {31'd0, busy}, 32'd0);
        check("load1_done_prog", {31'd0, prog}, 32'd0);
        check("load1_frames_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("load1_done_pulses", done_cnt, 1);
        check("load1_byte_cnt_hold", {23'd0, byte_cnt}, 32'd258);

        // abort inside the data bits of frame 3
        push_image();
        pulse_start();
        check("abort_run_cnt_clear", {23'd0, byte_cnt}, 32'd0);
        off = $urandom_range(GAP_CYC + CLK_DIV, GAP_CYC + 9 * CLK_DIV - 1);
        n = 0;
        while (n < LEAD_CYC + 3 * FRAME + off) begin
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_prog", {31'd0, prog}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_byte_cnt", {23'd0, byte_cnt}, 32'd3);
        check("abort_frames_left", exp_q.size(), 255);
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, 1);
        check("abort_cnt_hold", {23'd0, byte_cnt}, 32'd3);

        // reload, then reset during the gap of frame 100
        push_image();
        pulse_start();
        check("reload_cnt_clear", {23'd0, byte_cnt}, 32'd0);
        off = $urandom_range(0, GAP_CYC - 1);
        n = 0;
        while (n < LEAD_CYC + 100 * FRAME + off) begin
            @(negedge clk);
            n++;
        end
        nRst = 1'b0;
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_prog", {31'd0, prog}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_byte_cnt", {23'd0, byte_cnt}, 32'd0);
        check("midrst_rd_addr", {24'd0, rd_addr}, 32'hFF);
        nRst = 1'b1;
        check("midrst_frames_left", exp_q.size(), 158);
        exp_q.delete();

        // random image, loopback into a model of the up program memory
        for (int a = 0; a < 256; a++) begin
            mem[a]    = 8'($urandom);
            rx_mem[a] = ~mem[a];
        end
        repeat (5) @(negedge clk);
        push_image();
        pulse_start();
        n = 0;
        while (done !== 1'b1 && n < LOAD_LAT + 1000) begin
            @(negedge clk);
            n++;
        end
        check("load2_latency", n, LOAD_LAT);
        check("load2_byte_cnt", {23'd0, byte_cnt}, 32'd258);
        check("load2_frames_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("load2_done_pulses", done_cnt, 2);
        bad = 0;
        for (int a = 0; a < 256; a++) if (rx_mem[a] !== mem[a]) bad++;
        check("loopback_mem", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
